fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage; successor to the single-cycle fetch path.
//  Holds the fetch PC and issues word requests to a synchronous instruction memory (fixed 1-cycle latency).
//  Buffers {pc, inst} in a FQ_DEPTH-entry fetch queue and hands them to decode over a valid/ready handshake.
//  Branch/jump redirects flush all younger work.
// PARAMETERS
//  ADDR_W    32  PC / memory address width
//  INST_W    32  instruction width
//  RESET_PC  0   fetch PC loaded on reset
//  PC_STEP   1   PC increment per instruction (word addressing)
//  FQ_DEPTH  4   fetch-queue entries; power of two, >=2 (elaboration error otherwise)
// PORTS
//  clk               in   1       clock, all state on rising edge
//  reset             in   1       synchronous, active-high
//  redirect_valid    in   1       redirect fetch this cycle
//  redirect_is_jump  in   1       1: take jump_target, 0: take branch_target
//  branch_target     in   ADDR_W  branch target PC
//  jump_target       in   ADDR_W  jump target PC
//  imem_req          out  1       read request this cycle
//  imem_addr         out  ADDR_W  read address (= fetch PC)
//  imem_rdata        in   INST_W  data for the request issued on the previous cycle
//  out_valid         out  1       queue head valid to decode
//  out_ready         in   1       decode accepts head
//  out_inst          out  INST_W  head instruction
//  out_pc            out  ADDR_W  head PC
//  out_pc_next       out  ADDR_W  out_pc + PC_STEP (mod 2^ADDR_W)
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC; queue empty; inflight=0; imem_req=0; out_valid=0.
//    out_inst/out_pc/out_pc_next hold their last value and are don't-care while out_valid=0.
//  - deq = out_valid & out_ready.
//  - Issue condition: imem_req = !reset & !redirect_valid & (count + inflight - deq < FQ_DEPTH).
//    The deq term allows 1 instr/cycle sustained at FQ_DEPTH=2.
//  - On imem_req:
//    * imem_addr = fetch_pc.
//    * fetch_pc <= fetch_pc + PC_STEP (wraps at 2^ADDR_W).
//    * Records {inflight=1, inflight_pc=fetch_pc}; otherwise inflight <= 0.
//  - Response: cycle after a request with inflight=1, {inflight_pc, imem_rdata} is enqueued at the tail.
//    No bypass: first out_valid is 2 cycles after the first imem_req.
//  - Queue: circular buffer; simultaneous enqueue+dequeue allowed at any occupancy.
//    Overflow is impossible by the issue rule (assertion in sim).
//  - out_valid = !empty & !redirect_valid.
//    Head is stable while out_valid & !out_ready (stall).
//  - Redirect (highest priority, beats stall/deq/enqueue):
//    * fetch_pc <= redirect_is_jump ? jump_target : branch_target.
//    * Queue cleared; inflight <= 0, so any response arriving next cycle is discarded.
//    * No request in the redirect cycle; first request from the new target on the next cycle.
//  - Reset mid-operation: same as reset; pending response discarded.
//  - Back-to-back redirects: the last one wins; each flushes.
//  - FSM-free: state = fetch_pc, inflight, inflight_pc, queue rd/wr pointers, count.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    * Adds outputs perf_fetched, perf_flushed, perf_stall (32 bit each, wrap, reset 0).
//    * perf_fetched += deq.
//    * perf_flushed += (count + enqueued response discarded) on each redirect.
//    * perf_stall += (out_valid & !out_ready).
//  Not defined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. reset 3 cycles, out_ready=1, mem[i]=0x100+i
//     -> imem_addr 0,1,2,... one per cycle; first out_valid 2 cycles after the first req
//        with out_inst=0x100, out_pc=0, out_pc_next=1; then 1 instr/cycle.
//  2. FQ_DEPTH=4, out_ready=0 for 10 cycles
//     -> exactly 4 requests (addr 0..3), out_valid=1 and head (pc 0) stable;
//        release -> pc 0,1,2,3,4 in order with no gap.
//  3. redirect_valid=1, redirect_is_jump=1, jump_target=0x40 with 3 entries queued plus 1 inflight
//     -> out_valid=0 that cycle; next cycle imem_addr=0x40;
//        first out_pc=0x40, no older PC ever appears.
//  4. redirect_is_jump=0, branch_target=0x20 on two consecutive cycles (second 0x30)
//     -> only 0x30 fetched; 0x20 never issued.
//  5. fetch_pc=2^ADDR_W-1 with ADDR_W=8
//     -> next imem_addr=0x00; out_pc_next of head 0xFF = 0x00.
//  6. FETCH_PERF_CNT_EN: scenario 3 after 5 delivered instrs with 2 stall cycles
//     -> perf_fetched=5, perf_flushed=4, perf_stall=2.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - signal bundle between the fetch unit, its redirect source, instruction memory and decode
//
// Signals (master = fetch unit side):
//   redirect_valid    in   redirect fetch this cycle
//   redirect_is_jump  in   1: take jump_target, 0: take branch_target
//   branch_target     in   branch target PC
//   jump_target       in   jump target PC
//   imem_req          out  instruction-memory read request
//   imem_addr         out  read address (fetch PC)
//   imem_rdata        in   read data for the previous cycle's request
//   out_valid         out  queue head valid to decode
//   out_ready         in   decode accepts head
//   out_inst          out  head instruction
//   out_pc            out  head PC
//   out_pc_next       out  head PC + PC_STEP
//   perf_fetched/perf_flushed/perf_stall  out  only when FETCH_PERF_CNT_EN is defined
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              redirect_valid;
    logic              redirect_is_jump;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc_next;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_flushed;
    logic [31:0]       perf_stall;
`endif

    modport master (
        input  redirect_valid, redirect_is_jump, branch_target, jump_target,
        input  imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_next
`ifdef FETCH_PERF_CNT_EN
        , output perf_fetched, perf_flushed, perf_stall
`endif
    );

    modport slave (
        output redirect_valid, redirect_is_jump, branch_target, jump_target,
        output imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc_next
`ifdef FETCH_PERF_CNT_EN
        , input perf_fetched, perf_flushed, perf_stall
`endif
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage with 1-cycle memory, fetch queue and redirect flush
//
// Ports:
//   clk    in   clock, all state on rising edge
//   reset  in   synchronous, active-high
//   bus    fetch_unit_if.master: redirect inputs, imem request/response, decode valid/ready
// Optional feature macro: FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed/perf_stall counters.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1),
    parameter int                FQ_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_unit: FQ_DEPTH must be a power of two and at least 2");
    end

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] pc_mem   [FQ_DEPTH];
    logic [INST_W-1:0] inst_mem [FQ_DEPTH];

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              empty;
    logic              out_valid;
    logic              deq;
    logic              enq;
    logic [CNT_W:0]    occupancy;
    logic              issue;

    assign redirect    = bus.redirect_valid;
    assign redirect_pc = bus.redirect_is_jump ? bus.jump_target : bus.branch_target;
    assign empty       = (count_q == '0);
    assign out_valid   = !reset && !empty && !redirect;
    assign deq         = out_valid && bus.out_ready;
    // The response to last cycle's request lands now unless a redirect or reset discards it.
    assign enq         = inflight_q && !redirect && !reset;

    // Entries held plus the one in flight, less the one leaving this cycle; counting the
    // departing entry lets a 2-deep queue still sustain one instruction per cycle.
    assign occupancy   = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(deq);
    assign issue       = !reset && !redirect && (occupancy < (CNT_W+1)'(FQ_DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            // Redirect overrides stall, dequeue and enqueue: everything younger is dropped.
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + PC_STEP;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
            count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue payload needs no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            inst_mem[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_inst    = inst_mem[rd_ptr_q];
    assign bus.out_pc      = pc_mem[rd_ptr_q];
    assign bus.out_pc_next = pc_mem[rd_ptr_q] + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] perf_stall_q;
    logic [31:0] flush_amt;

    // Work lost on a redirect: queued entries plus the response that would have landed now.
    assign flush_amt = 32'(count_q) + 32'(inflight_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(deq);
            perf_stall_q   <= perf_stall_q + 32'(out_valid && !bus.out_ready);
            if (redirect) begin
                perf_flushed_q <= perf_flushed_q + flush_amt;
            end
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_flushed = perf_flushed_q;
    assign bus.perf_stall   = perf_stall_q;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(enq && !deq && count_q == CNT_W'(FQ_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit (ADDR_W=8, FQ_DEPTH=4)
module tb_fetch_unit;

    typedef struct {
        logic       rst;
        logic       rv;
        logic       rj;
        logic [7:0] bt;
        logic [7:0] jt;
        logic       rdy;
        logic       e_req;
        logic [7:0] e_addr;
        logic       e_valid;
        logic [7:0] e_pc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    bit   seen_20;
    vec_t vecs[$];

    fetch_unit_if #(.ADDR_W(8), .INST_W(32)) bus ();

    fetch_unit #(
        .ADDR_W  (8),
        .INST_W  (32),
        .RESET_PC(8'h00),
        .PC_STEP (8'h01),
        .FQ_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: mem[a] = 0x100 + a, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= 32'h100 + {24'h0, bus.imem_addr};
    end

    always @(posedge clk) begin
        if (!reset && bus.imem_req && bus.imem_addr == 8'h20) seen_20 = 1'b1;
    end

    task automatic add(input logic rst, input logic rv, input logic rj, input logic [7:0] bt,
                       input logic [7:0] jt, input logic rdy, input logic e_req,
                       input logic [7:0] e_addr, input logic e_valid, input logic [7:0] e_pc);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rj = rj; v.bt = bt; v.jt = jt; v.rdy = rdy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic apply(input logic rst, input logic rv, input logic rj, input logic [7:0] bt,
                         input logic [7:0] jt, input logic rdy);
        @(negedge clk);
        reset                = rst;
        bus.redirect_valid   = rv;
        bus.redirect_is_jump = rj;
        bus.branch_target    = bt;
        bus.jump_target      = jt;
        bus.out_ready        = rdy;
        #1;
        n_vec++;
    endtask

    task automatic chk(input string tag, input int idx, input logic e_req, input logic [7:0] e_addr,
                       input logic e_valid, input logic [7:0] e_pc);
        logic [7:0]  e_next;
        logic [31:0] e_inst;
        e_next = e_pc + 8'd1;
        e_inst = 32'h100 + {24'h0, e_pc};
        if (bus.imem_req !== e_req) begin
            $display("FAIL %s[%0d] imem_req got %0b exp %0b", tag, idx, bus.imem_req, e_req);
            n_err++;
        end
        if (e_req && bus.imem_addr !== e_addr) begin
            $display("FAIL %s[%0d] imem_addr got %h exp %h", tag, idx, bus.imem_addr, e_addr);
            n_err++;
        end
        if (bus.out_valid !== e_valid) begin
            $display("FAIL %s[%0d] out_valid got %0b exp %0b", tag, idx, bus.out_valid, e_valid);
            n_err++;
        end
        if (e_valid) begin
            if (bus.out_pc !== e_pc) begin
                $display("FAIL %s[%0d] out_pc got %h exp %h", tag, idx, bus.out_pc, e_pc);
                n_err++;
            end
            if (bus.out_pc_next !== e_next) begin
                $display("FAIL %s[%0d] out_pc_next got %h exp %h", tag, idx, bus.out_pc_next, e_next);
                n_err++;
            end
            if (bus.out_inst !== e_inst) begin
                $display("FAIL %s[%0d] out_inst got %h exp %h", tag, idx, bus.out_inst, e_inst);
                n_err++;
            end
        end
    endtask

    task automatic step(input string tag, input int idx, input logic rst, input logic rv,
                        input logic rj, input logic [7:0] bt, input logic [7:0] jt, input logic rdy,
                        input logic e_req, input logic [7:0] e_addr, input logic e_valid,
                        input logic [7:0] e_pc);
        apply(rst, rv, rj, bt, jt, rdy);
        chk(tag, idx, e_req, e_addr, e_valid, e_pc);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        seen_20 = 1'b0;
        reset   = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_is_jump = 1'b0;
        bus.branch_target    = 8'h00;
        bus.jump_target      = 8'h00;
        bus.out_ready        = 1'b0;

        // Streaming with decode always ready.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h03, 1, 8'h01);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h04, 1, 8'h02);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h05, 1, 8'h03);
        // Decode stalled 10 cycles: queue fills with 4, head stays at pc 0.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h01, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h02, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h03, 1, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1, 8'h00);
        // Release: pc 0..4 with no gap, refill resumes at addr 4.
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h04, 1, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h05, 1, 8'h01);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h06, 1, 8'h02);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h07, 1, 8'h03);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h08, 1, 8'h04);
        // Jump to 0x40 with 3 queued + 1 in flight.
        add(0, 1, 1, 8'h00, 8'h40, 1, 0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h42, 1, 8'h40);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h43, 1, 8'h41);
        // Back-to-back branches 0x20 then 0x30: only 0x30 fetched.
        add(0, 1, 0, 8'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        add(0, 1, 0, 8'h30, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h31, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h32, 1, 8'h30);
        // PC wrap at 0xFF.
        add(0, 1, 0, 8'hFF, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'hFF, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 1, 8'hFF);
        add(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 1, 8'h00);

        foreach (vecs[i]) begin
            step("vec", i, vecs[i].rst, vecs[i].rv, vecs[i].rj, vecs[i].bt, vecs[i].jt, vecs[i].rdy,
                 vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_pc);
        end

        // Reset with a response pending: the stale response must not reach the queue.
        step("rstmid", 0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        step("rstmid", 1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 0, 8'h00);
        step("rstmid", 2, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h01, 0, 8'h00);
        step("rstmid", 3, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 1, 8'h00);

        // Two stall cycles, five deliveries, then a jump flushing 3 queued + 1 in flight.
        step("perf", 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00);
        step("perf", 1, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00, 0, 8'h00);
        step("perf", 2, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h01, 0, 8'h00);
        step("perf", 3, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h02, 1, 8'h00);
        step("perf", 4, 0, 0, 0, 8'h00, 8'h00, 0, 1, 8'h03, 1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step("perf", 5 + i, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'(4 + i), 1, 8'(i));
        end
        step("perf", 10, 0, 1, 1, 8'h00, 8'h40, 1, 0, 8'h00, 0, 8'h00);
        step("perf", 11, 0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 0, 8'h00);
`ifdef FETCH_PERF_CNT_EN
        if (bus.perf_fetched !== 32'd5) begin
            $display("FAIL perf_fetched got %0d exp 5", bus.perf_fetched);
            n_err++;
        end
        if (bus.perf_flushed !== 32'd4) begin
            $display("FAIL perf_flushed got %0d exp 4", bus.perf_flushed);
            n_err++;
        end
        if (bus.perf_stall !== 32'd2) begin
            $display("FAIL perf_stall got %0d exp 2", bus.perf_stall);
            n_err++;
        end
`endif

        if (seen_20) begin
            $display("FAIL no_issue_0x20 got issued exp never");
            n_err++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
